// File: rtl/barrel_shift_pipe.sv
// Pipelined WIDTH-bit barrel shifter (rotate / logical / arithmetic / pass), one register per shift bit,
// valid/ready flow control with a sideband tag. Define BSHIFT_FLAGS_EN to add out_zero / out_carry.
module barrel_shift_pipe #(
    parameter  int WIDTH = 8,
    parameter  int TAG_W = 4,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shift,
    input  logic             in_dir,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef BSHIFT_FLAGS_EN
    ,
    output logic             out_zero,
    output logic             out_carry
`endif
);
    localparam logic [1:0] M_ROT  = 2'b00;
    localparam logic [1:0] M_ARI  = 2'b10;
    localparam logic [1:0] M_PASS = 2'b11;

    // rem is the shift count still to apply, pre-aligned so its LSB belongs to the next stage
    typedef struct packed {
        logic [SHW-1:0] rem;
        logic           dir;
        logic [1:0]     mode;
        logic           msb;
    } ctl_t;

    logic [SHW-1:0]            vld_pipe;
    logic [SHW-1:0][WIDTH-1:0] dat;
    logic [SHW-1:0][TAG_W-1:0] tag;
    ctl_t [SHW-2:0]            ctl;
    logic [SHW:0]              rdy;
`ifdef BSHIFT_FLAGS_EN
    logic [SHW-1:0]            cry;
`endif

    assign rdy[SHW] = out_ready;

    for (genvar k = 0; k < SHW; k++) begin : g_stg
        localparam int S = 1 << k;

        logic             v_i;
        logic [WIDTH-1:0] d_i;
        logic [WIDTH-1:0] d_o;
        logic [TAG_W-1:0] t_i;
        ctl_t             c_i;
        logic             hit;
        logic             v_q;
        logic [WIDTH-1:0] d_q;
        logic [TAG_W-1:0] t_q;

        if (k == 0) begin : g_src
            assign v_i = in_valid;
            assign d_i = in_data;
            assign t_i = in_tag;
            assign c_i = {in_shift, in_dir, in_mode, in_data[WIDTH-1]};
        end else begin : g_src
            assign v_i = vld_pipe[k-1];
            assign d_i = dat[k-1];
            assign t_i = tag[k-1];
            assign c_i = ctl[k-1];
        end

        if (k < SHW-1) begin : g_hit
            assign hit = c_i.rem[0] && (c_i.mode != M_PASS);
        end else begin : g_hit
            // by the last stage only the LSB of rem can still be set
            assign hit = (|c_i.rem) && (c_i.mode != M_PASS);
        end

        always_comb begin
            d_o = d_i;
            if (hit) begin
                if (c_i.mode == M_ROT)
                    d_o = c_i.dir ? {d_i[S-1:0], d_i[WIDTH-1:S]}
                                  : {d_i[WIDTH-S-1:0], d_i[WIDTH-1:WIDTH-S]};
                else if (c_i.dir)
                    d_o = {{S{(c_i.mode == M_ARI) && c_i.msb}}, d_i[WIDTH-1:S]};
                else
                    d_o = {d_i[WIDTH-S-1:0], {S{1'b0}}};
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_q <= 1'b0;
                d_q <= '0;
                t_q <= '0;
            end else if (rdy[k]) begin
                v_q <= v_i;
                if (v_i) begin
                    d_q <= d_o;
                    t_q <= t_i;
                end
            end
        end

        assign vld_pipe[k] = v_q;
        assign dat[k]      = d_q;
        assign tag[k]      = t_q;
        assign rdy[k]      = !v_q || rdy[k+1];

        if (k < SHW-1) begin : g_ctl
            ctl_t c_q;
            always_ff @(posedge clk) begin
                if (!rst_n)
                    c_q <= '0;
                else if (rdy[k] && v_i)
                    c_q <= {c_i.rem >> 1, c_i.dir, c_i.mode, c_i.msb};
            end
            assign ctl[k] = c_q;
        end

`ifdef BSHIFT_FLAGS_EN
        logic cy_i;
        logic cy_q;
        if (k == 0) begin : g_cy
            assign cy_i = 1'b0;
        end else begin : g_cy
            assign cy_i = cry[k-1];
        end

        // the last active stage's outgoing edge bit is the overall last bit shifted/wrapped out
        always_ff @(posedge clk) begin
            if (!rst_n)
                cy_q <= 1'b0;
            else if (rdy[k] && v_i)
                cy_q <= hit ? (c_i.dir ? d_i[S-1] : d_i[WIDTH-S]) : cy_i;
        end
        assign cry[k] = cy_q;

        if (k == SHW-1) begin : g_zero
            logic z_q;
            always_ff @(posedge clk) begin
                if (!rst_n)
                    z_q <= 1'b0;
                else if (rdy[k] && v_i)
                    z_q <= (d_o == '0);
            end
            assign out_zero = z_q;
        end
`endif
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld_pipe[SHW-1];
    assign out_data  = dat[SHW-1];
    assign out_tag   = tag[SHW-1];
`ifdef BSHIFT_FLAGS_EN
    assign out_carry = cry[SHW-1];
`endif

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Bench for barrel_shift_pipe: queue-based reference model checked on every output transfer,
// plus directed vectors with hand-computed results (WIDTH=8 and one WIDTH=32 instance).
module tb_barrel_shift_pipe;
    localparam int W  = 8;
    localparam int TW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid, in_ready, in_dir, out_valid, out_ready;
    logic [W-1:0]  in_data, out_data;
    logic [2:0]    in_shift;
    logic [1:0]    in_mode;
    logic [TW-1:0] in_tag, out_tag;
    logic          v32, r32, ov32, or32, dir32;
    logic [31:0]   d32, od32;
    logic [4:0]    s32;
    logic [1:0]    m32;
    logic [TW-1:0] t32, ot32;
`ifdef BSHIFT_FLAGS_EN
    logic          out_zero, out_carry, z32, c32;
`endif

    barrel_shift_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_shift(in_shift),
        .in_dir(in_dir), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
`ifdef BSHIFT_FLAGS_EN
        , .out_zero(out_zero), .out_carry(out_carry)
`endif
    );

    barrel_shift_pipe #(.WIDTH(32), .TAG_W(TW)) dut32 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v32), .in_ready(r32), .in_data(d32), .in_shift(s32),
        .in_dir(dir32), .in_mode(m32), .in_tag(t32),
        .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_tag(ot32)
`ifdef BSHIFT_FLAGS_EN
        , .out_zero(z32), .out_carry(c32)
`endif
    );

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // reference: whole-word arithmetic on the original operand; returns {carry, data}
    function automatic logic [W:0] model(input logic [W-1:0] d, input int s, input logic dir,
                                         input logic [1:0] mode);
        logic [W-1:0] r;
        logic         c;
        if (mode == 2'b11 || s == 0) return {1'b0, d};
        c = dir ? d[s-1] : d[W-s];
        if (mode == 2'b00) begin
            if (dir) r = (d >> s) | (d << (W - s));
            else     r = (d << s) | (d >> (W - s));
        end else if (mode == 2'b10 && dir) begin
            r = $signed(d) >>> s;
        end else begin
            if (dir) r = d >> s;
            else     r = d << s;
        end
        return {c, r};
    endfunction

    typedef struct { logic [W-1:0] d; logic [TW-1:0] t; logic z; logic c; } beat_t;
    typedef struct { logic [W-1:0] d; logic [TW-1:0] t; logic z; logic c; int cyc; } obs_t;
    beat_t expq[$];
    obs_t  obs[$];

    int           cyc = 0;
    logic         stall_q = 1'b0;
    logic [W-1:0] hold_d;
    logic [TW-1:0] hold_t;

    always @(negedge clk) begin
        beat_t      e;
        obs_t       o;
        logic [W:0] m;
        cyc++;
        if (!rst_n) begin
            expq.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q && out_valid) begin
                check("hold_data", out_data, hold_d);
                check("hold_tag", out_tag, hold_t);
            end
            if (out_valid && out_ready) begin
                o.d = out_data; o.t = out_tag; o.cyc = cyc; o.z = 1'b0; o.c = 1'b0;
`ifdef BSHIFT_FLAGS_EN
                o.z = out_zero; o.c = out_carry;
`endif
                obs.push_back(o);
                if (expq.size() == 0) begin
                    nvec++; nmis++;
                    $display("FAIL spurious_beat: tag 0x%0h emitted, expected no beat", out_tag);
                end else begin
                    e = expq.pop_front();
                    check("model_data", out_data, e.d);
                    check("model_tag", out_tag, e.t);
`ifdef BSHIFT_FLAGS_EN
                    check("model_zero", out_zero, e.z);
                    check("model_carry", out_carry, e.c);
`endif
                end
            end
            if (in_valid && in_ready) begin
                m = model(in_data, int'(in_shift), in_dir, in_mode);
                e.d = m[W-1:0]; e.c = m[W]; e.z = (m[W-1:0] == '0); e.t = in_tag;
                expq.push_back(e);
            end
            stall_q = out_valid && !out_ready;
            hold_d  = out_data;
            hold_t  = out_tag;
        end
    end

    task automatic send(input logic [W-1:0] d, input int s, input logic dir,
                        input logic [1:0] mode, input logic [TW-1:0] t);
        logic done;
        done = 1'b0;
        in_valid = 1'b1; in_data = d; in_shift = 3'(s); in_dir = dir; in_mode = mode; in_tag = t;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk); #1;
        end
        if (!done) begin
            nvec++; nmis++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 64 cycles");
        end
    endtask

    task automatic wait_obs(input int n, input string name);
        for (int i = 0; i < 100 && obs.size() < n; i++) @(posedge clk);
        repeat (4) @(posedge clk);
        #1;
        check(name, obs.size(), n);
    endtask

    logic [W-1:0] bb_d [4] = '{8'hA5, 8'h12, 8'hF2, 8'h0E};
    logic [W-1:0] bp_d [5] = '{8'h22, 8'h44, 8'h66, 8'h88, 8'hAA};
    logic [W-1:0] bd_d [6] = '{8'hA7, 8'hA7, 8'hA7, 8'hA7, 8'h5C, 8'h3C};
    logic [W:0]   pin;
    logic         hs;
    int           idx, lat;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shift = '0; in_dir = 1'b0;
        in_mode = '0; in_tag = '0; out_ready = 1'b1;
        v32 = 1'b0; d32 = '0; s32 = '0; dir32 = 1'b0; m32 = '0; t32 = '0; or32 = 1'b1;

        // model pins
        pin = model(8'h96, 3, 1'b0, 2'b00); check("pin_rotl", pin, {1'b0, 8'hB4});
        pin = model(8'h96, 3, 1'b1, 2'b10); check("pin_asr", pin, {1'b1, 8'hF2});
        pin = model(8'h01, 1, 1'b1, 2'b00); check("pin_rotr", pin, {1'b1, 8'h80});

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_in_ready", in_ready, 1);

        // latency and first result
        @(posedge clk); #1;
        send(8'h96, 3, 1'b0, 2'b00, 4'h5);
        in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check("lat_w8", lat, 3);
        check("rotl_data", out_data, 8'hB4);
        check("rotl_tag", out_tag, 4'h5);

        // back-to-back mixed modes
        repeat (3) @(posedge clk); #1;
        obs.delete();
        send(8'h96, 2, 1'b1, 2'b00, 4'd1);
        send(8'h96, 3, 1'b1, 2'b01, 4'd2);
        send(8'h96, 3, 1'b1, 2'b10, 4'd3);
        send(8'h76, 3, 1'b1, 2'b10, 4'd4);
        in_valid = 1'b0;
        wait_obs(4, "b2b_count");
        if (obs.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                check("b2b_data", obs[i].d, bb_d[i]);
                check("b2b_tag", obs[i].t, i + 1);
                check("b2b_gap", obs[i].cyc - obs[0].cyc, i);
            end

        // backpressure
        obs.delete();
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 40 && idx < 5; c++) begin
            if (c == 8) out_ready = 1'b1;
            in_valid = 1'b1; in_data = 8'(8'h11 * (idx + 1)); in_shift = 3'd1;
            in_dir = 1'b0; in_mode = 2'b00; in_tag = 4'(idx + 1);
            @(negedge clk);
            if (c == 7) begin
                check("bp_accepted", idx, 3);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_hold_tag", out_tag, 1);
                check("bp_hold_data", out_data, 8'h22);
            end
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) idx++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", idx, 5);
        wait_obs(5, "bp_count");
        if (obs.size() >= 5)
            for (int i = 0; i < 5; i++) begin
                check("bp_data", obs[i].d, bp_d[i]);
                check("bp_tag", obs[i].t, i + 1);
                check("bp_gap", obs[i].cyc - obs[0].cyc, i);
            end

        // reset with three beats in flight
        obs.delete();
        out_ready = 1'b0;
        send(8'h0F, 1, 1'b0, 2'b01, 4'd9);
        send(8'hF0, 2, 1'b1, 2'b10, 4'd10);
        send(8'h3C, 3, 1'b0, 2'b00, 4'd11);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_out_valid", out_valid, 0);
        check("rstmid_out_data", out_data, 0);
        check("rstmid_out_tag", out_tag, 0);
        check("rstmid_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (8) @(posedge clk); #1;
        check("rstmid_no_ghost", obs.size(), 0);

        // shift 0 in every mode, pass-through ignores shift/dir
        obs.delete();
        for (int m = 0; m < 4; m++) send(8'hA7, 0, m[0], 2'(m), 4'(m + 1));
        send(8'h5C, 5, 1'b1, 2'b11, 4'd5);
        send(8'h3C, 7, 1'b0, 2'b11, 4'd6);
        in_valid = 1'b0;
        wait_obs(6, "bnd_count");
        if (obs.size() >= 6)
            for (int i = 0; i < 6; i++) check("bnd_data", obs[i].d, bd_d[i]);

`ifdef BSHIFT_FLAGS_EN
        obs.delete();
        send(8'h80, 1, 1'b0, 2'b01, 4'd1);
        send(8'h01, 1, 1'b1, 2'b00, 4'd2);
        in_valid = 1'b0;
        wait_obs(2, "flg_count");
        if (obs.size() >= 2) begin
            check("flg_lsl_data", obs[0].d, 8'h00);
            check("flg_lsl_zero", obs[0].z, 1);
            check("flg_lsl_carry", obs[0].c, 1);
            check("flg_rotr_data", obs[1].d, 8'h80);
            check("flg_rotr_zero", obs[1].z, 0);
            check("flg_rotr_carry", obs[1].c, 1);
        end
`endif

        // mixed stream with intermittent backpressure, checked by the model
        idx = 0;
        for (int c = 0; c < 300 && idx < 48; c++) begin
            out_ready = (c % 4) != 3;
            in_valid = 1'b1; in_data = 8'(idx * 53 + 29); in_shift = 3'(idx % 8);
            in_dir = idx[0]; in_mode = 2'((idx / 2) % 4); in_tag = 4'(idx);
            @(negedge clk);
            hs = in_ready;
            @(posedge clk); #1;
            if (hs) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("mix_accepted", idx, 48);
        repeat (10) @(posedge clk); #1;
        check("drained", expq.size(), 0);

        // WIDTH=32 instance
        v32 = 1'b1; d32 = 32'h8000_0001; s32 = 5'd31; dir32 = 1'b0; m32 = 2'b00; t32 = 4'd7;
        @(negedge clk);
        check("w32_in_ready", r32, 1);
        @(posedge clk); #1;
        v32 = 1'b0;
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            lat++;
            if (ov32) break;
        end
        check("lat_w32", lat, 5);
        check("w32_data", od32, 32'hC000_0000);
        check("w32_tag", ot32, 4'd7);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/barrel_shift_pipe.md
Name: barrel_shift_pipe

Overview:
Parametrised, pipelined barrel shifter. Successor to the team's fixed 4-bit combinational rotator.
- Generalised to WIDTH bits.
- Adds logical and arithmetic shift modes alongside rotate.
- Carries a sideband tag through the pipeline.
- One register stage per shift bit, with valid/ready flow control. Sits between the operand-fetch stream and the ALU writeback stream.

Parameters:
WIDTH, 8, data width; power of two, >= 4; SHW = clog2(WIDTH) is derived internally.
TAG_W, 4, width of sideband tag carried alongside each beat.

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input beat this cycle
in_data  input  WIDTH  operand
in_shift  input  SHW  shift amount, 0..WIDTH-1
in_dir  input  1  0 = left, 1 = right
in_mode  input  2  00 rotate, 01 logical, 10 arithmetic, 11 pass-through
in_tag  input  TAG_W  sideband tag, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_data  output  WIDTH  shifted result
out_tag  output  TAG_W  tag of the beat on out_data

Behaviour:
- Reset: on rising clk with rst_n=0, all stage valids clear and all stage data/tag registers clear.
  - Next cycle: out_valid=0, out_data=0, out_tag=0, in_ready=1.
  - In-flight beats are discarded and never emitted.
- Pipeline has SHW stages, k = 0..SHW-1.
  - Stage k shifts its operand by 2^k when shift bit k is 1, otherwise passes it through.
  - Every stage is registered. The last stage drives out_* directly.
- Latency: exactly SHW cycles from input handshake to out_valid with out_ready held 1. Throughput is one beat per cycle.
- Handshake:
  - A transfer occurs when valid && ready are both high on a rising edge.
  - Stage k loads when it is empty, or when its content moves to stage k+1 in the same cycle.
  - The last stage empties when out_ready=1.
  - in_ready = stage 0 empty OR stage 0 advancing (combinational from downstream ready chain; no combinational path from in_valid).
  - While out_valid=1 and out_ready=0, out_data and out_tag hold stable.
  - Beats are never dropped, duplicated or reordered.
- Each beat carries its own dir, mode, shift and original MSB through the stages. Mixed modes back-to-back are legal.
- Rotate:
  - Left: bits leaving the MSB enter the LSB.
  - Right: bits leaving the LSB enter the MSB.
  - Matches the existing 4-bit rotator for WIDTH=4.
- Logical: vacated positions fill with 0.
- Arithmetic:
  - Right: vacated MSBs fill with in_data[WIDTH-1] of the original operand.
  - Left: identical to logical left.
- Mode 11 ignores shift and dir; out_data = in_data.
- in_shift = 0 yields out_data = in_data in every mode.
- Simultaneous in handshake and out handshake in a full pipeline is legal and sustains full throughput.

Optional Feature:
Macro BSHIFT_FLAGS_EN.
- Defined: adds two outputs, out_zero (1 bit) and out_carry (1 bit), registered and aligned with out_data/out_valid.
  - out_zero = (out_data == 0).
  - out_carry, logical/arithmetic modes: the last bit shifted out. For left this is original bit WIDTH-shift; for right it is original bit shift-1.
  - out_carry, rotate mode: the last bit that wrapped around.
  - out_carry = 0 when shift = 0 or mode = 11.
  - Both outputs reset to 0 and hold under backpressure.
- Not defined: ports and flag logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, rotate left, 0x96 by 3, out_ready=1 -> out_data=0xB4 exactly 3 cycles after handshake; out_tag equals in_tag.
- Rotate right 0x96 by 2 -> 0xA5. Logical right 0x96 by 3 -> 0x12. Arithmetic right 0x96 by 3 -> 0xF2. Arithmetic right 0x76 by 3 -> 0x0E. Issue all back-to-back, one per cycle; results appear on consecutive cycles.
- Backpressure: out_ready=0 while 5 beats (tags 1..5) are offered.
  - in_ready falls after 3 beats accepted.
  - out_data holds the tag-1 result.
  - Release out_ready: tags 1..5 emerge in order with no gaps once flowing; no loss.
- Reset mid-operation: 3 beats in flight, rst_n=0 for one edge -> out_valid=0 and out_data=0 the next cycle; none of the 3 beats ever appears.
- Boundaries: shift=0 with any mode returns the operand. Mode 11 with shift 5 returns the operand. WIDTH=32, rotate left 0x80000001 by 31 -> 0xC0000000 after 5 cycles.
- BSHIFT_FLAGS_EN:
  - Logical left 0x80 by 1 -> out_data=0x00, out_zero=1, out_carry=1.
  - Rotate right 0x01 by 1 -> 0x80, out_zero=0, out_carry=1.
